// File: rtl/gamma_cycle_sequencer.sv
// rtl/gamma_cycle_sequencer.sv - gamma-cycle sequencer for one exclusive_max race-logic unit
// Optional macro GAMMA_SEQ_QIN_REG_EN registers q_in before capture and stretches RUN by one cycle.
module gamma_cycle_sequencer #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  localparam int TW               = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic          aclk,
  input  logic          grst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [TW-1:0] a_time,
  input  logic [TW-1:0] b_time,
  input  logic          a_null,
  input  logic          b_null,
  output logic          gamma_rst,
  output logic          a_spike,
  output logic          b_spike,
  input  logic          q_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [TW-1:0] out_time,
  output logic          out_null,
  output logic          busy
);

  // One extra counter bit so cnt can reach GAMMA_CYCLE_WIDTH and time+PULSE_WIDTH never overflows.
  localparam int CW = TW + 1;
  localparam logic [CW-1:0] GCW = CW'(GAMMA_CYCLE_WIDTH);
  localparam logic [CW-1:0] PW  = CW'(PULSE_WIDTH);
`ifdef GAMMA_SEQ_QIN_REG_EN
  localparam logic [CW-1:0] LAST = CW'(GAMMA_CYCLE_WIDTH);
`else
  localparam logic [CW-1:0] LAST = CW'(GAMMA_CYCLE_WIDTH - 1);
`endif

  typedef enum logic [1:0] {IDLE, GRST, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [TW-1:0] a_t, b_t, res_time;
  logic          a_n, b_n, hit;
  logic          capture;
  logic [TW-1:0] cap_val;

`ifdef GAMMA_SEQ_QIN_REG_EN
  logic q_d;

  always_ff @(posedge aclk) begin
    if (grst) q_d <= 1'b0;
    else      q_d <= q_in;
  end

  // q_d at cnt=0 still reflects the GRST cycle, so it is not a valid hit.
  assign capture = (state == RUN) && (cnt != '0) && q_d && !hit;
  assign cap_val = TW'(cnt - CW'(1));
`else
  assign capture = (state == RUN) && q_in && !hit;
  assign cap_val = cnt[TW-1:0];
`endif

  function automatic logic pulse_on(input logic [CW-1:0] c, input logic [TW-1:0] t,
                                    input logic n);
    logic [CW-1:0] s;
    s = {1'b0, t};
    return !n && (c >= s) && (c < s + PW) && (c < GCW);
  endfunction

  always_ff @(posedge aclk) begin
    if (grst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_t      <= '0;
      b_t      <= '0;
      a_n      <= 1'b0;
      b_n      <= 1'b0;
      hit      <= 1'b0;
      res_time <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          a_t      <= a_time;
          b_t      <= b_time;
          a_n      <= a_null || ({1'b0, a_time} >= GCW);
          b_n      <= b_null || ({1'b0, b_time} >= GCW);
          hit      <= 1'b0;
          res_time <= '0;
        end
        GRST: cnt <= '0;
        RUN: begin
          cnt <= cnt + CW'(1);
          if (capture) begin
            hit      <= 1'b1;
            res_time <= cap_val;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    gamma_rst = 1'b0;
    a_spike   = 1'b0;
    b_spike   = 1'b0;
    out_valid = 1'b0;
    out_time  = '0;
    out_null  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = GRST;
      end
      GRST: begin
        gamma_rst = 1'b1;
        state_nx  = RUN;
      end
      RUN: begin
        a_spike = pulse_on(cnt, a_t, a_n);
        b_spike = pulse_on(cnt, b_t, b_n);
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_time  = res_time;
        out_null  = !hit;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_gamma_cycle_sequencer.sv
// tb/tb_gamma_cycle_sequencer.sv - directed/scoreboard bench with a behavioural exclusive_max load
module tb_gamma_cycle_sequencer;
  localparam int GCW = 16;
  localparam int PW  = 8;
  localparam int TW  = 4;
`ifdef GAMMA_SEQ_QIN_REG_EN
  localparam int RUN_LEN = GCW + 1;
`else
  localparam int RUN_LEN = GCW;
`endif

  logic          aclk, grst;
  logic          in_valid, in_ready;
  logic [TW-1:0] a_time, b_time;
  logic          a_null, b_null;
  logic          gamma_rst, a_spike, b_spike, q_in;
  logic          out_valid, out_ready, out_null, busy;
  logic [TW-1:0] out_time;

  gamma_cycle_sequencer #(.GAMMA_CYCLE_WIDTH(GCW), .PULSE_WIDTH(PW)) dut (
    .aclk(aclk), .grst(grst), .in_valid(in_valid), .in_ready(in_ready),
    .a_time(a_time), .b_time(b_time), .a_null(a_null), .b_null(b_null),
    .gamma_rst(gamma_rst), .a_spike(a_spike), .b_spike(b_spike), .q_in(q_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_time(out_time),
    .out_null(out_null), .busy(busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // exclusive_max: q follows a&b once both are high, unless they rose in the same cycle.
  logic xa_prev, xb_prev, x_tie;
  always @(posedge aclk) begin
    if (gamma_rst) begin
      xa_prev <= 1'b0;
      xb_prev <= 1'b0;
      x_tie   <= 1'b0;
    end else begin
      xa_prev <= a_spike;
      xb_prev <= b_spike;
      if (a_spike && b_spike && !xa_prev && !xb_prev) x_tie <= 1'b1;
    end
  end
  assign q_in = a_spike & b_spike & ~x_tie & (xa_prev | xb_prev);

  typedef struct {
    logic [TW-1:0] t;
    logic          n;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic exp_spike(input int t, input logic n, input int k);
    return !n && (k < GCW) && (k >= t) && (k < t + PW);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_gamma_rst"}, gamma_rst, 0);
    check({tag, "_spikes"}, {a_spike, b_spike}, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_time"}, out_time, 0);
    check({tag, "_out_null"}, out_null, 0);
  endtask

  // rst_at >= 0 asserts grst in the RUN cycle with that cnt and abandons the operation.
  task automatic run_op(input int at, input int bt, input logic an, input logic bn,
                        input int et, input logic en, input int hold, input int rst_at);
    exp_t e, got;
    @(negedge aclk);
    check("idle_in_ready", in_ready, 1);
    a_time    = TW'(at);
    b_time    = TW'(bt);
    a_null    = an;
    b_null    = bn;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    e.t = TW'(et);
    e.n = en;
    sb.push_back(e);
    @(negedge aclk);
    in_valid = 1'b0;
    check("grst_pulse", gamma_rst, 1);
    check("grst_in_ready", in_ready, 0);
    for (int k = 0; k < RUN_LEN; k++) begin
      @(negedge aclk);
      check("a_spike", a_spike, exp_spike(at, an, k));
      check("b_spike", b_spike, exp_spike(bt, bn, k));
      check("run_out_valid", out_valid, 0);
      check("run_busy", busy, 1);
      if (k == rst_at) begin
        grst = 1'b1;
        @(negedge aclk);
        grst = 1'b0;
        sb.delete();
        check_reset_outputs("midrun_reset");
        return;
      end
    end
    @(negedge aclk);
    check("done_out_valid", out_valid, 1);
    check("done_in_ready", in_ready, 0);
    if (hold > 0) begin
      in_valid = 1'b1;
      a_time   = 4'd1;
      b_time   = 4'd2;
      for (int h = 0; h < hold; h++) begin
        @(negedge aclk);
        check("hold_out_valid", out_valid, 1);
        check("hold_out_time", out_time, e.t);
        check("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      got = sb.pop_front();
      check("out_time", out_time, got.t);
      check("out_null", out_null, got.n);
    end
    @(negedge aclk);
    check("after_out_valid", out_valid, 0);
    check("after_busy", busy, 0);
    check("after_in_ready", in_ready, 1);
  endtask

  initial begin
    int ra, rb, lo, hi, et;
    logic en;
    grst = 1'b1; in_valid = 1'b0; a_time = '0; b_time = '0;
    a_null = 1'b0; b_null = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge aclk);
    check_reset_outputs("reset");
    grst = 1'b0;

    run_op(3, 7, 1'b0, 1'b0, 7, 1'b0, 0, -1);
    run_op(5, 5, 1'b0, 1'b0, 0, 1'b1, 0, -1);
    run_op(3, 12, 1'b0, 1'b0, 0, 1'b1, 0, -1);
    run_op(0, 4, 1'b1, 1'b0, 0, 1'b1, 0, -1);
    run_op(14, 10, 1'b0, 1'b0, 14, 1'b0, 5, -1);
    run_op(2, 9, 1'b0, 1'b0, 9, 1'b0, 0, 6);
    run_op(1, 4, 1'b0, 1'b0, 4, 1'b0, 0, -1);
    run_op(0, 1, 1'b0, 1'b0, 1, 1'b0, 0, -1);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom_range(15, 0);
      rb = $urandom_range(15, 0);
      lo = (ra < rb) ? ra : rb;
      hi = (ra < rb) ? rb : ra;
      en = !((ra != rb) && (hi < lo + PW) && (hi < GCW));
      et = en ? 0 : hi;
      run_op(ra, rb, 1'b0, 1'b0, et, en, i % 2, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
